// File: rtl/hazard_ctl_if.sv
// rtl/hazard_ctl_if.sv - hazard controller signal bundle between the pipeline and hazard_ctl
// master: pipeline side driving stage info; slave: the hazard controller.
interface hazard_ctl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs_ID;
  logic [4:0]       Rt_ID;
  logic             UsesRs_ID;
  logic             UsesRt_ID;
  logic [4:0]       WriteReg_EX;
  logic             RegWrite_EX;
  logic             MemToReg_EX;
  logic [4:0]       WriteReg_ME;
  logic             RegWrite_ME;
  logic             Stall_EX;
  logic             BranchTaken_EX;

  logic             AnyStall;
  logic             HoldFront;
  logic             BubbleEX;
  logic             FlushFront;
  logic [1:0]       FwdA_EX;
  logic [1:0]       FwdB_EX;
  logic             Timeout;
  logic [CNT_W-1:0] StallCycles;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output Rs_ID, Rt_ID, UsesRs_ID, UsesRt_ID,
    output WriteReg_EX, RegWrite_EX, MemToReg_EX,
    output WriteReg_ME, RegWrite_ME, Stall_EX, BranchTaken_EX,
    input  AnyStall, HoldFront, BubbleEX, FlushFront,
    input  FwdA_EX, FwdB_EX, Timeout, StallCycles, FlushCount
  );

  modport slave (
    input  Rs_ID, Rt_ID, UsesRs_ID, UsesRt_ID,
    input  WriteReg_EX, RegWrite_EX, MemToReg_EX,
    input  WriteReg_ME, RegWrite_ME, Stall_EX, BranchTaken_EX,
    output AnyStall, HoldFront, BubbleEX, FlushFront,
    output FwdA_EX, FwdB_EX, Timeout, StallCycles, FlushCount
  );
endinterface

// File: rtl/hazard_ctl.sv
// rtl/hazard_ctl.sv - five-stage pipeline stall/flush/forward controller with EX busy watchdog
// HAZARD_FWD_EN: enables operand forwarding (only load-use stalls); undefined: stall on any RAW.
module hazard_ctl #(
  parameter int STALL_MAX = 64,
  parameter int CNT_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  hazard_ctl_if.slave hz
);

  localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_BUSY = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       busy_cnt_q, busy_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic any_stall;
  logic hold_front;
  logic bubble_ex;
  logic flush_front;
  logic dep_stall;

  // Register zero is hardwired, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] src, input logic used,
                                     input logic [4:0] dst, input logic wr);
    return used && wr && (src != 5'd0) && (src == dst);
  endfunction

  logic ex_rs, ex_rt, me_rs, me_rt, ex_load, load_use;

  assign ex_rs    = reg_match(hz.Rs_ID, hz.UsesRs_ID, hz.WriteReg_EX, hz.RegWrite_EX);
  assign ex_rt    = reg_match(hz.Rt_ID, hz.UsesRt_ID, hz.WriteReg_EX, hz.RegWrite_EX);
  assign me_rs    = reg_match(hz.Rs_ID, hz.UsesRs_ID, hz.WriteReg_ME, hz.RegWrite_ME);
  assign me_rt    = reg_match(hz.Rt_ID, hz.UsesRt_ID, hz.WriteReg_ME, hz.RegWrite_ME);
  assign ex_load  = hz.RegWrite_EX & hz.MemToReg_EX;
  assign load_use = ex_load & (ex_rs | ex_rt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      busy_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_cnt_q  <= busy_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // The first busy cycle is taken in RUN, so the counter already holds 1 on entering BUSY.
  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    timeout_d  = timeout_q;
    any_stall  = 1'b0;
    case (state_q)
      ST_RUN: begin
        busy_cnt_d = 8'd0;
        if (hz.Stall_EX) begin
          any_stall  = 1'b1;
          busy_cnt_d = 8'd1;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (hz.Stall_EX) begin
          any_stall  = 1'b1;
          busy_cnt_d = busy_cnt_q + 8'd1;
          if (busy_cnt_q + 8'd1 == STALL_LIM) begin
            state_d   = ST_DEAD;
            timeout_d = 1'b1;
          end
        end else begin
          busy_cnt_d = 8'd0;
          state_d    = ST_RUN;
        end
      end
      ST_DEAD: begin
        busy_cnt_d = 8'd0;
        if (!hz.Stall_EX) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        busy_cnt_d = 8'd0;
        state_d    = ST_RUN;
      end
    endcase
  end

`ifdef HAZARD_FWD_EN
  assign dep_stall = load_use;
`else
  assign dep_stall = load_use | ex_rs | ex_rt | me_rs | me_rt;
`endif

  // A taken branch squashes the dependent instruction, so its stall is pointless.
  always_comb begin
    hold_front  = 1'b0;
    bubble_ex   = 1'b0;
    flush_front = 1'b0;
    if (!any_stall) begin
      if (hz.BranchTaken_EX) begin
        flush_front = 1'b1;
      end else if (dep_stall) begin
        hold_front = 1'b1;
        bubble_ex  = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((any_stall || hold_front) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_front && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [1:0] sel_a, sel_b;

  // A load in EX never forwards from EX; that case is the load-use bubble.
  always_comb begin
    sel_a = 2'b00;
    sel_b = 2'b00;
    if (ex_rs && !hz.MemToReg_EX) begin
      sel_a = 2'b01;
    end else if (me_rs) begin
      sel_a = 2'b10;
    end
    if (ex_rt && !hz.MemToReg_EX) begin
      sel_b = 2'b01;
    end else if (me_rt) begin
      sel_b = 2'b10;
    end
  end

  always_comb begin
    fwd_a_d = sel_a;
    fwd_b_d = sel_b;
    if (any_stall) begin
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
    end else if (bubble_ex || flush_front) begin
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign hz.FwdA_EX = fwd_a_q;
  assign hz.FwdB_EX = fwd_b_q;
`else
  assign hz.FwdA_EX = 2'b00;
  assign hz.FwdB_EX = 2'b00;
`endif

  assign hz.AnyStall    = any_stall;
  assign hz.HoldFront   = hold_front;
  assign hz.BubbleEX    = bubble_ex;
  assign hz.FlushFront  = flush_front;
  assign hz.Timeout     = timeout_q;
  assign hz.StallCycles = stall_cnt_q;
  assign hz.FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctl.sv
// tb/tb_hazard_ctl.sv - directed vector table and corner sequences for hazard_ctl
module tb_hazard_ctl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  hazard_ctl_if #(.CNT_W(16)) hif ();

  hazard_ctl #(.STALL_MAX(64), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] wex;
    logic       rwex, mtr;
    logic [4:0] wme;
    logic       rwme, br;
    logic       hold, bub, flush;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                              input logic urt, input logic [4:0] wex, input logic rwex,
                              input logic mtr, input logic [4:0] wme, input logic rwme,
                              input logic br, input logic hold, input logic flush,
                              input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.wex = wex; v.rwex = rwex; v.mtr = mtr;
    v.wme = wme; v.rwme = rwme; v.br = br;
    v.hold = hold; v.bub = hold; v.flush = flush; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    hif.Rs_ID = 5'd0; hif.Rt_ID = 5'd0; hif.UsesRs_ID = 1'b0; hif.UsesRt_ID = 1'b0;
    hif.WriteReg_EX = 5'd0; hif.RegWrite_EX = 1'b0; hif.MemToReg_EX = 1'b0;
    hif.WriteReg_ME = 5'd0; hif.RegWrite_ME = 1'b0;
    hif.Stall_EX = 1'b0; hif.BranchTaken_EX = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    hif.Rs_ID = v.rs; hif.Rt_ID = v.rt; hif.UsesRs_ID = v.urs; hif.UsesRt_ID = v.urt;
    hif.WriteReg_EX = v.wex; hif.RegWrite_EX = v.rwex; hif.MemToReg_EX = v.mtr;
    hif.WriteReg_ME = v.wme; hif.RegWrite_ME = v.rwme; hif.BranchTaken_EX = v.br;
    hif.Stall_EX = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int hi;
    int base_cnt;
    logic [1:0] base_fa;
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_any",   hif.AnyStall, 0);
    chk("rst_hold",  hif.HoldFront, 0);
    chk("rst_bub",   hif.BubbleEX, 0);
    chk("rst_flush", hif.FlushFront, 0);
    chk("rst_to",    hif.Timeout, 0);
    chk("rst_fa",    hif.FwdA_EX, 0);
    chk("rst_fb",    hif.FwdB_EX, 0);
    chk("rst_scnt",  hif.StallCycles, 0);
    chk("rst_fcnt",  hif.FlushCount, 0);
    reset = 1'b0;
    tick();

    //            rs  rt urs urt wex rwex mtr wme rwme br  hold      flush fa               fb
    vecs[0]  = mk(0,  0, 0,  0,  0,  0,   0,  0,  0,   0,  0,        0,    2'b00,           2'b00);
    vecs[1]  = mk(3,  0, 1,  0,  3,  1,   0,  0,  0,   0,  !FWD,     0,    FWD ? 2'b01 : 2'b00, 2'b00);
    vecs[2]  = mk(0,  0, 1,  0,  0,  1,   0,  0,  0,   0,  0,        0,    2'b00,           2'b00);
    vecs[3]  = mk(0,  5, 0,  1,  5,  1,   1,  0,  0,   0,  1,        0,    2'b00,           2'b00);
    vecs[4]  = mk(0,  7, 0,  1,  0,  0,   0,  7,  1,   0,  !FWD,     0,    2'b00,           FWD ? 2'b10 : 2'b00);
    vecs[5]  = mk(4,  0, 1,  0,  4,  1,   0,  4,  1,   0,  !FWD,     0,    FWD ? 2'b01 : 2'b00, 2'b00);
    vecs[6]  = mk(3,  0, 0,  0,  3,  1,   0,  0,  0,   0,  0,        0,    2'b00,           2'b00);
    vecs[7]  = mk(3,  0, 1,  0,  3,  0,   0,  0,  0,   0,  0,        0,    2'b00,           2'b00);
    vecs[8]  = mk(0,  5, 0,  1,  5,  1,   1,  0,  0,   1,  0,        1,    2'b00,           2'b00);
    vecs[9]  = mk(3,  0, 1,  0,  3,  1,   0,  0,  0,   1,  0,        1,    2'b00,           2'b00);
    vecs[10] = mk(6,  9, 1,  1,  9,  1,   0,  6,  1,   0,  !FWD,     0,    FWD ? 2'b10 : 2'b00, FWD ? 2'b01 : 2'b00);
    vecs[11] = mk(0,  0, 1,  1,  0,  0,   0,  0,  1,   0,  0,        0,    2'b00,           2'b00);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d_hold", i),  hif.HoldFront,  vecs[i].hold);
      chk($sformatf("vec%0d_bub", i),   hif.BubbleEX,   vecs[i].bub);
      chk($sformatf("vec%0d_flush", i), hif.FlushFront, vecs[i].flush);
      chk($sformatf("vec%0d_any", i),   hif.AnyStall,   0);
      tick();
      chk($sformatf("vec%0d_fa", i),    hif.FwdA_EX,    vecs[i].fa);
      chk($sformatf("vec%0d_fb", i),    hif.FwdB_EX,    vecs[i].fb);
      idle();
    end

    // Load-use: LW r5 in EX, then the load moves to ME.
    do_reset();
    hif.WriteReg_EX = 5'd5; hif.RegWrite_EX = 1'b1; hif.MemToReg_EX = 1'b1;
    hif.Rt_ID = 5'd5; hif.UsesRt_ID = 1'b1;
    #1;
    chk("lu_hold0", hif.HoldFront, 1);
    chk("lu_bub0",  hif.BubbleEX, 1);
    tick();
    hif.RegWrite_EX = 1'b0; hif.MemToReg_EX = 1'b0; hif.WriteReg_EX = 5'd0;
    hif.WriteReg_ME = 5'd5; hif.RegWrite_ME = 1'b1;
    #1;
    chk("lu_hold1", hif.HoldFront, !FWD);
    tick();
    chk("lu_fwdb", hif.FwdB_EX, FWD ? 2'b10 : 2'b00);
    chk("lu_scnt", hif.StallCycles, FWD ? 1 : 2);
    idle();

    // ADD r3 in EX feeding Rs.
    do_reset();
    hif.WriteReg_EX = 5'd3; hif.RegWrite_EX = 1'b1; hif.Rs_ID = 5'd3; hif.UsesRs_ID = 1'b1;
    #1;
    chk("add_hold0", hif.HoldFront, !FWD);
    tick();
    chk("add_fwda", hif.FwdA_EX, FWD ? 2'b01 : 2'b00);
    hif.RegWrite_EX = 1'b0; hif.WriteReg_EX = 5'd0;
    hif.WriteReg_ME = 5'd3; hif.RegWrite_ME = 1'b1; hif.UsesRs_ID = !FWD;
    #1;
    chk("add_hold1", hif.HoldFront, !FWD);
    tick();
    idle();
    #1;
    chk("add_hold2", hif.HoldFront, 0);
    chk("add_scnt", hif.StallCycles, FWD ? 2 - 2 : 2);
    tick();

    // EX busy for 3 cycles masks a coincident load-use and branch.
    do_reset();
    hif.WriteReg_EX = 5'd3; hif.RegWrite_EX = 1'b1; hif.Rs_ID = 5'd3; hif.UsesRs_ID = 1'b1;
    tick();
    base_fa  = FWD ? 2'b01 : 2'b00;
    base_cnt = FWD ? 0 : 1;
    idle();
    hif.Stall_EX = 1'b1; hif.BranchTaken_EX = 1'b1;
    hif.WriteReg_EX = 5'd5; hif.RegWrite_EX = 1'b1; hif.MemToReg_EX = 1'b1;
    hif.Rt_ID = 5'd5; hif.UsesRt_ID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("st%0d_any", k),   hif.AnyStall, 1);
      chk($sformatf("st%0d_hold", k),  hif.HoldFront, 0);
      chk($sformatf("st%0d_bub", k),   hif.BubbleEX, 0);
      chk($sformatf("st%0d_flush", k), hif.FlushFront, 0);
      tick();
      chk($sformatf("st%0d_fa", k),    hif.FwdA_EX, base_fa);
    end
    idle();
    #1;
    chk("st_any_end", hif.AnyStall, 0);
    chk("st_scnt",    hif.StallCycles, base_cnt + 3);
    chk("st_fcnt",    hif.FlushCount, 0);
    tick();

    // Branch coincident with load-use plus an ME forward candidate.
    do_reset();
    hif.WriteReg_EX = 5'd3; hif.RegWrite_EX = 1'b1; hif.Rs_ID = 5'd3; hif.UsesRs_ID = 1'b1;
    tick();
    idle();
    hif.BranchTaken_EX = 1'b1;
    hif.WriteReg_EX = 5'd5; hif.RegWrite_EX = 1'b1; hif.MemToReg_EX = 1'b1;
    hif.Rt_ID = 5'd5; hif.UsesRt_ID = 1'b1;
    hif.WriteReg_ME = 5'd3; hif.RegWrite_ME = 1'b1; hif.Rs_ID = 5'd3; hif.UsesRs_ID = 1'b1;
    #1;
    chk("br_flush", hif.FlushFront, 1);
    chk("br_hold",  hif.HoldFront, 0);
    chk("br_bub",   hif.BubbleEX, 0);
    tick();
    chk("br_fa",   hif.FwdA_EX, 0);
    chk("br_fb",   hif.FwdB_EX, 0);
    chk("br_fcnt", hif.FlushCount, 1);
    idle();

    // Watchdog: Stall_EX held 70 cycles.
    do_reset();
    hif.Stall_EX = 1'b1;
    hi = 0;
    for (int k = 0; k < 70; k++) begin
      #1;
      if (hif.AnyStall === 1'b1) hi++;
      if (k == 63) chk("wd_to_early", hif.Timeout, 0);
      if (k == 64) chk("wd_to_rise",  hif.Timeout, 1);
      tick();
    end
    chk("wd_any_cycles", hi, 64);
    hif.Stall_EX = 1'b0;
    #1;
    chk("wd_any_rel",  hif.AnyStall, 0);
    chk("wd_to_stick", hif.Timeout, 1);
    chk("wd_scnt",     hif.StallCycles, 64);
    tick();
    chk("wd_to_stick2", hif.Timeout, 1);

    // Reset pulsed while BUSY.
    hif.Stall_EX = 1'b1;
    tick(); tick(); tick();
    #2;
    reset = 1'b1;
    hif.Stall_EX = 1'b0;
    #1;
    chk("rb_any",  hif.AnyStall, 0);
    chk("rb_hold", hif.HoldFront, 0);
    chk("rb_to",   hif.Timeout, 0);
    chk("rb_scnt", hif.StallCycles, 0);
    chk("rb_fcnt", hif.FlushCount, 0);
    chk("rb_fa",   hif.FwdA_EX, 0);
    chk("rb_fb",   hif.FwdB_EX, 0);
    tick();
    reset = 1'b0;
    hif.Stall_EX = 1'b1;
    hi = 0;
    for (int k = 0; k < 66; k++) begin
      #1;
      if (hif.AnyStall === 1'b1) hi++;
      tick();
    end
    chk("rb_any_cycles", hi, 64);
    chk("rb_to_after",   hif.Timeout, 1);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
